// File: rtl/lsu.sv
// Load/store unit: one outstanding word-bus access, posted stores, registered writeback.
// Misaligned or illegal accesses raise a one-cycle fault and never reach the bus.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] reg_out,
    input  logic            mm_we,
    input  logic            mm_re,
    output logic            stall,
    output logic [XLEN-1:0] rd_data,
    output logic            fault,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:2]   r_addr;
    logic [1:0]        r_off;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_wstrb;
    logic [XLEN-1:0]   r_ldbuf;
    logic [XLEN-1:0]   r_rd;
    logic              r_fault;

    logic              w_idle;
    logic              w_mis;
    logic              w_ld_go;
    logic              w_st_go;
    logic              w_ld_bad;
    logic              w_st_bad;
    logic [3:0]        w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_ldfmt;

    // Access checks; size 11 is never legal, so it folds into the misalignment term
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_mis    = ((funct3[1:0] == 2'b01) && result[0]) ||
                   ((funct3[1:0] == 2'b10) && (result[1:0] != 2'b00)) ||
                   (funct3[1:0] == 2'b11);
        w_ld_go  = w_idle && mm_re && !w_mis && !(funct3[2] && funct3[1]);
        w_ld_bad = w_idle && mm_re && !w_ld_go;
        w_st_go  = w_idle && mm_we && !mm_re && !w_mis && !funct3[2];
        w_st_bad = w_idle && mm_we && !mm_re && !w_st_go;
    end

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = reg_out;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << result[1:0];
                w_wdata = {4{reg_out[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << result[1:0];
                w_wdata = {2{reg_out[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shift = bus_rdata >> {r_off, 3'b000};
        case (r_f3)
            3'b000:  w_ldfmt = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_ldfmt = {24'h0, w_shift[7:0]};
            3'b001:  w_ldfmt = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_ldfmt = {16'h0, w_shift[15:0]};
            default: w_ldfmt = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ld_go)      w_next = S_RD;
                else if (w_st_go) w_next = S_WR;
            end
            S_RD:   if (bus_ack) w_next = S_DONE;
            S_WR:   if (bus_ack) w_next = S_IDLE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // stall deliberately ignores mm_we so the store can be posted in its issue cycle
    always_comb begin
        bus_req = (r_state == S_RD) || (r_state == S_WR);
        bus_we  = (r_state == S_WR);
        stall   = w_ld_go || bus_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_f3    <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_ldbuf <= '0;
            r_rd    <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_ld_go) begin
                r_addr  <= result[XLEN-1:2];
                r_off   <= result[1:0];
                r_f3    <= funct3;
                r_wstrb <= 4'b0000;
            end else if (w_st_go) begin
                r_addr  <= result[XLEN-1:2];
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end
            if ((r_state == S_RD) && bus_ack)
                r_ldbuf <= w_ldfmt;
            r_fault <= w_ld_bad || w_st_bad;
            if (!stall) begin
                if (r_state == S_DONE) r_rd <= r_ldbuf;
                else if (w_ld_bad)     r_rd <= '0;
                else                   r_rd <= result;
            end
        end
    end

    assign rd_data   = r_rd;
    assign fault     = r_fault;
    assign bus_addr  = {r_addr, 2'b00};
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;

endmodule

// File: tb/tb_lsu.sv
// Directed + randomized bench for lsu; expectations come from a transaction-level model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  funct3;
    logic [31:0] result;
    logic [31:0] reg_out;
    logic        mm_we;
    logic        mm_re;
    logic        stall;
    logic [31:0] rd_data;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_rd;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .funct3(funct3), .result(result), .reg_out(reg_out),
        .mm_we(mm_we), .mm_re(mm_re), .stall(stall), .rd_data(rd_data), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules expressed as byte-lane arithmetic
    function automatic bit acc_ok(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (f3[1:0] == 2'b11) return 1'b0;
        if (ld && f3 >= 3'd6) return 1'b0;
        if (!ld && f3[2]) return 1'b0;
        sz = 1 << f3[1:0];
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz;
        logic [31:0] v;
        logic [31:0] mask;
        sz = 1 << f3[1:0];
        v = w >> (8 * (a % 4));
        if (sz == 4) return v;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return {24'h0, d[7:0]} * 32'h01010101;
        if (f3[1:0] == 2'b01) return {16'h0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] st_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return ((32'h1 << sz) - 32'h1) << (a % 4);
    endfunction

    task automatic alu(input logic [31:0] v);
        mm_re = 1'b0; mm_we = 1'b0; result = v; #1;
        chk("alu_stall", stall, 0);
        tick();
        exp_rd = v;
        chk("alu_rd", rd_data, exp_rd);
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w, input int dly);
        bit ok;
        logic [31:0] nxt;
        ok = acc_ok(1'b1, f3, a);
        mm_re = 1'b1; mm_we = 1'b0; funct3 = f3; result = a; bus_ack = 1'b0; #1;
        chk("ld_issue_stall", stall, ok);
        chk("ld_issue_req", bus_req, 0);
        tick();
        if (!ok) begin
            nxt = $urandom;
            mm_re = 1'b0; result = nxt; #1;
            chk("ld_fault", fault, 1);
            chk("ld_fault_rd", rd_data, 0);
            chk("ld_fault_req", bus_req, 0);
            chk("ld_fault_stall", stall, 0);
            tick();
            exp_rd = nxt;
            chk("ld_fault_clr", fault, 0);
            chk("ld_fault_next_rd", rd_data, exp_rd);
            return;
        end
        for (int d = 0; d <= dly; d++) begin
            bus_ack = (d == dly);
            bus_rdata = (d == dly) ? w : $urandom;
            #1;
            chk("ld_rd_stall", stall, 1);
            chk("ld_rd_req", bus_req, 1);
            chk("ld_rd_we", bus_we, 0);
            chk("ld_rd_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("ld_rd_strb", bus_wstrb, 0);
            chk("ld_rd_hold", rd_data, exp_rd);
            tick();
        end
        bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom; #1;
        chk("ld_done_stall", stall, 0);
        chk("ld_done_req", bus_req, 0);
        tick();
        exp_rd = ld_val(f3, a, w);
        mm_re = 1'b0; bus_ack = 1'b0; result = $urandom; #1;
        chk("ld_data", rd_data, exp_rd);
        chk("ld_idle_req", bus_req, 0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int dly, input logic [31:0] nxt);
        bit ok;
        ok = acc_ok(1'b0, f3, a);
        mm_we = 1'b1; mm_re = 1'b0; funct3 = f3; result = a; reg_out = d; bus_ack = 1'b0; #1;
        chk("st_issue_stall", stall, 0);
        chk("st_issue_req", bus_req, 0);
        tick();
        exp_rd = a;
        mm_we = 1'b0; result = nxt;
        if (!ok) begin
            #1;
            chk("st_fault", fault, 1);
            chk("st_fault_rd", rd_data, exp_rd);
            chk("st_fault_req", bus_req, 0);
            tick();
            exp_rd = nxt;
            chk("st_fault_clr", fault, 0);
            chk("st_fault_next_rd", rd_data, exp_rd);
            return;
        end
        for (int k = 0; k <= dly; k++) begin
            bus_ack = (k == dly); #1;
            chk("st_wr_stall", stall, 1);
            chk("st_wr_req", bus_req, 1);
            chk("st_wr_we", bus_we, 1);
            chk("st_wr_addr", bus_addr, a & 32'hFFFF_FFFC);
            chk("st_wr_data", bus_wdata, st_data(f3, d));
            chk("st_wr_strb", bus_wstrb, st_strb(f3, a));
            chk("st_wr_hold", rd_data, exp_rd);
            chk("st_wr_fault", fault, 0);
            tick();
        end
        bus_ack = 1'b0; #1;
        chk("st_drain_stall", stall, 0);
        chk("st_drain_req", bus_req, 0);
        tick();
        exp_rd = nxt;
        chk("st_next_rd", rd_data, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; funct3 = 3'b0; result = 32'h0; reg_out = 32'h0;
        mm_we = 1'b0; mm_re = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        exp_rd = 32'h0;
        tick(); tick();
        chk("rst_rd", rd_data, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_strb", bus_wstrb, 0);
        chk("rst_stall_idle", stall, 0);
        mm_re = 1'b1; funct3 = 3'b010; result = 32'h100; #1;
        chk("rst_stall_load", stall, 1);
        mm_re = 1'b0;
        tick();
        rst = 1'b0;

        alu(32'h1234);
        load(3'b000, 32'h103, 32'h80FF7F01, 0);
        chk("lb_const", rd_data, 32'hFFFFFF80);
        load(3'b101, 32'h102, 32'hBEEF1234, 1);
        chk("lhu_const", rd_data, 32'h0000BEEF);
        store(3'b001, 32'h22, 32'h0000ABCD, 2, 32'h55);
        load(3'b010, 32'h101, 32'h0, 0);
        load(3'b110, 32'h100, 32'h0, 0);
        store(3'b100, 32'h40, 32'h11, 0, 32'h66);
        store(3'b011, 32'h40, 32'h11, 0, 32'h77);
        alu(32'hCAFE_0001);

        // Reset while a load is outstanding, then a stale ack
        mm_re = 1'b1; mm_we = 1'b0; funct3 = 3'b010; result = 32'h200; #1;
        tick();
        mm_re = 1'b0; rst = 1'b1; result = 32'h0; #1;
        chk("inflight_req", bus_req, 1);
        tick();
        chk("rstfl_req", bus_req, 0);
        chk("rstfl_stall", stall, 0);
        chk("rstfl_rd", rd_data, 0);
        chk("rstfl_strb", bus_wstrb, 0);
        rst = 1'b0;
        tick(); tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
        chk("late_ack_req", bus_req, 0);
        chk("late_ack_stall", stall, 0);
        tick();
        bus_ack = 1'b0; #1;
        chk("late_ack_rd", rd_data, 0);
        chk("late_ack_req2", bus_req, 0);
        exp_rd = 32'h0;

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int          op;
            int          dly;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom & 32'h0000_0FFF;
            op  = $urandom_range(0, 2);
            dly = $urandom_range(0, 3);
            if (op == 0)      alu($urandom);
            else if (op == 1) load(f3, a, $urandom, dly);
            else              store(f3, a, $urandom, dly, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
